// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS pipeline.
//   Inputs : ID/EX pipeline register fields (ID_EX_*), MEM and WB forwarding
//            sources (MEM_EX_*, WB_EX_*), clk, EX_rst_n, EX_enable, EX_flush.
//   Outputs: EX/MEM pipeline register (EX_MEM_*), load-use hazard feedback
//            to ID (EX_ID_*), branch recovery and predictor/BTB update to IF
//            (EX_IF_*), and a saturating misprediction counter.
module ex_stage (
   input  logic        clk,
   input  logic        EX_rst_n,
   input  logic        EX_enable,
   input  logic        EX_flush,
   input  logic [31:0] ID_EX_output_data_1,
   input  logic [31:0] ID_EX_output_data_2,
   input  logic [4:0]  ID_EX_rs,
   input  logic [4:0]  ID_EX_rt,
   input  logic [4:0]  ID_EX_rd,
   input  logic [31:0] ID_EX_immediate_extended,
   input  logic [31:0] ID_EX_pc,
   input  logic        ID_EX_alusrc,
   input  logic [1:0]  ID_EX_alu_operation,
   input  logic        ID_EX_memory_read,
   input  logic        ID_EX_memory_write,
   input  logic        ID_EX_memory_to_register,
   input  logic        ID_EX_register_write,
   input  logic        ID_EX_branch,
   input  logic        ID_EX_branch_ne,
   input  logic [1:0]  ID_EX_predictor,
   input  logic [31:0] ID_EX_branch_target_predict,
   input  logic        MEM_EX_register_write,
   input  logic [4:0]  MEM_EX_write_register,
   input  logic [31:0] MEM_EX_alu_result,
   input  logic        WB_EX_register_write,
   input  logic [4:0]  WB_EX_write_register,
   input  logic [31:0] WB_EX_write_data,
   output logic [31:0] EX_MEM_alu_result,
   output logic [31:0] EX_MEM_write_data,
   output logic [4:0]  EX_MEM_write_register,
   output logic        EX_MEM_memory_read,
   output logic        EX_MEM_memory_write,
   output logic        EX_MEM_memory_to_register,
   output logic        EX_MEM_register_write,
   output logic [4:0]  EX_ID_rt,
   output logic        EX_ID_memory_read,
   output logic        EX_IF_redirect,
   output logic [31:0] EX_IF_redirect_pc,
   output logic        EX_IF_update_valid,
   output logic [31:0] EX_IF_update_pc,
   output logic [1:0]  EX_IF_update_predictor,
   output logic [31:0] EX_IF_update_target,
   output logic [15:0] EX_mispredict_count
);

   typedef struct packed {
      logic [31:0] alu_result;
      logic [31:0] write_data;
      logic [4:0]  write_register;
      logic        memory_read;
      logic        memory_write;
      logic        memory_to_register;
      logic        register_write;
   } exmem_t;

   logic [31:0] op_a, b_reg, op_b, alu_res, br_target;
   logic        taken, mispredict;
   exmem_t      exmem_d, exmem_q;
   logic [15:0] cnt_d, cnt_q;

   // Forwarding: MEM has priority over WB; r0 is never forwarded.
   always_comb begin
      op_a = ID_EX_output_data_1;
      if (MEM_EX_register_write && (MEM_EX_write_register != 5'd0) &&
          (MEM_EX_write_register == ID_EX_rs))
         op_a = MEM_EX_alu_result;
      else if (WB_EX_register_write && (WB_EX_write_register != 5'd0) &&
               (WB_EX_write_register == ID_EX_rs))
         op_a = WB_EX_write_data;
   end

   always_comb begin
      b_reg = ID_EX_output_data_2;
      if (MEM_EX_register_write && (MEM_EX_write_register != 5'd0) &&
          (MEM_EX_write_register == ID_EX_rt))
         b_reg = MEM_EX_alu_result;
      else if (WB_EX_register_write && (WB_EX_write_register != 5'd0) &&
               (WB_EX_write_register == ID_EX_rt))
         b_reg = WB_EX_write_data;
   end

   assign op_b = ID_EX_alusrc ? ID_EX_immediate_extended : b_reg;

   always_comb begin
      alu_res = '0;
      unique case (ID_EX_alu_operation)
         2'b00: alu_res = op_a + op_b;
         2'b01: alu_res = op_a - op_b;
         2'b11: alu_res = op_a | {16'h0000, ID_EX_immediate_extended[15:0]};
         default: begin
            // R-type: funct lives in the low bits of the sign-extended immediate
            case (ID_EX_immediate_extended[5:0])
               6'b100000: alu_res = op_a + op_b;
               6'b100010: alu_res = op_a - op_b;
               6'b100100: alu_res = op_a & op_b;
               6'b100101: alu_res = op_a | op_b;
               6'b101010: alu_res = {31'd0, ($signed(op_a) < $signed(op_b))};
               6'b000000: alu_res = b_reg << ID_EX_immediate_extended[10:6];
               default:   alu_res = '0;
            endcase
         end
      endcase
   end

   // Branch resolution against the 2-bit prediction from IF.
   assign br_target  = ID_EX_pc + {ID_EX_immediate_extended[29:0], 2'b00};
   assign taken      = (op_a == b_reg) ^ ID_EX_branch_ne;
   assign mispredict = ID_EX_branch &&
                       ((taken != ID_EX_predictor[1]) ||
                        (taken && ID_EX_predictor[1] &&
                         (ID_EX_branch_target_predict != br_target)));

   always_comb begin
      EX_IF_redirect         = 1'b0;
      EX_IF_redirect_pc      = '0;
      EX_IF_update_valid     = 1'b0;
      EX_IF_update_pc        = '0;
      EX_IF_update_predictor = '0;
      EX_IF_update_target    = '0;
      if (ID_EX_branch) begin
         EX_IF_redirect      = mispredict;
         EX_IF_redirect_pc   = taken ? br_target : ID_EX_pc;
         EX_IF_update_valid  = 1'b1;
         EX_IF_update_pc     = ID_EX_pc - 32'd4;
         EX_IF_update_target = br_target;
         if (taken)
            EX_IF_update_predictor = (ID_EX_predictor == 2'b11) ? 2'b11 : ID_EX_predictor + 2'b01;
         else
            EX_IF_update_predictor = (ID_EX_predictor == 2'b00) ? 2'b00 : ID_EX_predictor - 2'b01;
      end
   end

   assign EX_ID_rt          = ID_EX_rt;
   assign EX_ID_memory_read = ID_EX_memory_read;

   // EX/MEM next state: flush beats hold, so a flush during a stall still bubbles.
   always_comb begin
      exmem_d.alu_result         = alu_res;
      exmem_d.write_data         = b_reg;
      exmem_d.write_register     = (ID_EX_alu_operation == 2'b10) ? ID_EX_rd : ID_EX_rt;
      exmem_d.memory_read        = ID_EX_memory_read;
      exmem_d.memory_write       = ID_EX_memory_write;
      exmem_d.memory_to_register = ID_EX_memory_to_register;
      exmem_d.register_write     = ID_EX_register_write;
      if (EX_flush)
         exmem_d = '0;
      else if (!EX_enable)
         exmem_d = exmem_q;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (mispredict && EX_enable && (cnt_q != 16'hFFFF))
         cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge EX_rst_n) begin
      if (!EX_rst_n) begin
         exmem_q <= '0;
         cnt_q   <= '0;
      end else begin
         exmem_q <= exmem_d;
         cnt_q   <= cnt_d;
      end
   end

   assign EX_MEM_alu_result         = exmem_q.alu_result;
   assign EX_MEM_write_data         = exmem_q.write_data;
   assign EX_MEM_write_register     = exmem_q.write_register;
   assign EX_MEM_memory_read        = exmem_q.memory_read;
   assign EX_MEM_memory_write       = exmem_q.memory_write;
   assign EX_MEM_memory_to_register = exmem_q.memory_to_register;
   assign EX_MEM_register_write     = exmem_q.register_write;
   assign EX_mispredict_count       = cnt_q;

endmodule
